// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types and constants for the divider control stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int          DIV_W         = 32;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;
    localparam int          CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_control_if.sv
// ============================================================================
// div_control_if : handshake, operand, divider and result signals of the
//                  divider control stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface div_control_if;
    import div_pkg::*;

    logic               start;
    logic [DIV_W-1:0]   a_in;
    logic [DIV_W-1:0]   b_in;
    logic               ready;
    logic               busy;
    logic [DIV_W-1:0]   div_a;
    logic [DIV_W-1:0]   div_b;
    logic [2*DIV_W-1:0] div_c;
    logic [DIV_W-1:0]   hi_out;
    logic [DIV_W-1:0]   lo_out;
    logic               done;
    logic               div_zero;

    // The master side includes the external combinational divider (div_c).
    modport master (
        output start, a_in, b_in, div_c,
        input  ready, busy, div_a, div_b, hi_out, lo_out, done, div_zero
    );

    modport slave (
        input  start, a_in, b_in, div_c,
        output ready, busy, div_a, div_b, hi_out, lo_out, done, div_zero
    );

endinterface

`default_nettype wire

// File: rtl/div_control_cond_negate.sv
// ============================================================================
// cond_negate : y = sel ? -x : x (two's-complement, width W).
// Revision : 1.0
// ============================================================================
`default_nettype none

module cond_negate #(
    parameter int W = 32
) (
    input  wire logic [W-1:0] x,
    input  wire logic         sel,
    output      logic [W-1:0] y
);

    assign y = sel ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

`default_nettype wire

// File: rtl/div_control.sv
// ============================================================================
// div_control : multi-cycle sign/magnitude control around an external
//               unsigned combinational divider; loads HI/LO result registers.
//               Optional macro DIV_ZERO_TRAP_EN enables divide-by-zero trap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_control
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input wire logic     clock,
    input wire logic     clear,
    div_control_if.slave bus
);

    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [DIV_W-1:0]   r_div_a;
    logic [DIV_W-1:0]   r_div_b;
    logic [DIV_W-1:0]   r_hi;
    logic [DIV_W-1:0]   r_lo;
    logic [DIV_W-1:0]   w_mag_a;
    logic [DIV_W-1:0]   w_mag_b;
    logic [DIV_W-1:0]   w_quot;
    logic [DIV_W-1:0]   w_rem;
    logic               w_accept;
    logic               w_trap_now;

    assign w_accept = (r_state == IDLE) && bus.start;

    cond_negate #(.W(DIV_W)) u_mag_a (.x(bus.a_in), .sel(bus.a_in[DIV_W-1]), .y(w_mag_a));
    cond_negate #(.W(DIV_W)) u_mag_b (.x(bus.b_in), .sel(bus.b_in[DIV_W-1]), .y(w_mag_b));
    cond_negate #(.W(DIV_W)) u_fix_q (.x(bus.div_c[DIV_W-1:0]),       .sel(r_sign_q), .y(w_quot));
    cond_negate #(.W(DIV_W)) u_fix_r (.x(bus.div_c[2*DIV_W-1:DIV_W]), .sel(r_sign_r), .y(w_rem));

`ifdef DIV_ZERO_TRAP_EN
    logic               r_trap;
    logic               r_div_zero;
    logic [DIV_W-1:0]   r_a_raw;

    assign w_trap_now   = (bus.b_in == '0);
    assign bus.div_zero = r_div_zero;
`else
    assign w_trap_now   = 1'b0;
    assign bus.div_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = w_trap_now ? FIX : SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div_a  <= '0;
            r_div_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef DIV_ZERO_TRAP_EN
            r_trap     <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_div_a  <= w_mag_a;
                r_div_b  <= w_mag_b;
                r_sign_q <= bus.a_in[DIV_W-1] ^ bus.b_in[DIV_W-1];
                r_sign_r <= bus.a_in[DIV_W-1];
                r_cnt    <= '0;
`ifdef DIV_ZERO_TRAP_EN
                r_trap     <= w_trap_now;
                r_div_zero <= 1'b0;
                r_a_raw    <= bus.a_in;
`endif
            end

            if (r_state == SETTLE) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // div_c is only observed here, at the FIX edge.
            if (r_state == FIX) begin
`ifdef DIV_ZERO_TRAP_EN
                if (r_trap) begin
                    r_hi       <= r_a_raw;
                    r_lo       <= DIV_ZERO_QUOT;
                    r_div_zero <= 1'b1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
`else
                r_hi <= w_rem;
                r_lo <= w_quot;
`endif
            end
        end
    end

    assign bus.ready  = (r_state == IDLE);
    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.div_a  = r_div_a;
    assign bus.div_b  = r_div_b;
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_div_control.sv
// ============================================================================
// tb_div_control : scoreboard bench for div_control with a behavioural
//                  unsigned divider model on div_c.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_control;

    localparam int S = 2;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   n_done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          when;
    } exp_t;

    exp_t q[$];

    div_control_if bus ();

    div_control #(.SETTLE_CYCLES(S)) dut (
        .clock (clk),
        .clear (rst),
        .bus   (bus.slave)
    );

    // Behavioural unsigned divider; divide-by-zero gives all-ones quotient.
    always_comb begin
        if (bus.div_b == 32'd0) begin
            bus.div_c = {bus.div_a, 32'hFFFFFFFF};
        end else begin
            bus.div_c = {bus.div_a % bus.div_b, bus.div_a / bus.div_b};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            n_done++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("lo_out", bus.lo_out, e.lo);
                check("hi_out", bus.hi_out, e.hi);
                check("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
                check("done_cycle", cyc, e.when);
            end
        end
    end

    task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo,
                            input logic dz, input int lat);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz;
        e.when = cyc + 1 + lat;
        q.push_back(e);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (bus.ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=%b expected 1", bus.ready);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic dz, input int lat);
        @(negedge clk);
        wait_ready();
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        push_exp(hi, lo, dz, lat);
        @(negedge clk);
        bus.start = 1'b0;
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        cyc = 0; n_cmp = 0; n_bad = 0; n_done = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi_out, 32'd0);
        check("rst_lo", bus.lo_out, 32'd0);
        check("rst_div_a", bus.div_a, 32'd0);
        check("rst_div_b", bus.div_b, 32'd0);
        check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);

        // Sign combinations
        do_op(32'd17, 32'd5, 32'd2, 32'd3, 1'b0, S + 1);
        do_op(-32'sd17, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, S + 1);
        do_op(32'd17, -32'sd5, 32'd2, 32'hFFFFFFFD, 1'b0, S + 1);
        do_op(-32'sd17, -32'sd5, 32'hFFFFFFFE, 32'd3, 1'b0, S + 1);

        // Most-negative dividend
        @(negedge clk);
        wait_ready();
        bus.a_in = 32'h80000000; bus.b_in = 32'd1; bus.start = 1'b1;
        push_exp(32'd0, 32'h80000000, 1'b0, S + 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("div_a_minint", bus.div_a, 32'h80000000);
        check("div_b_one", bus.div_b, 32'd1);
        check("busy_settle", {31'd0, bus.busy}, 32'd1);
        drain();

        // Divide by zero
`ifdef DIV_ZERO_TRAP_EN
        do_op(32'd42, 32'd0, 32'd42, 32'hFFFFFFFF, 1'b1, 1);
`else
        do_op(32'd42, 32'd0, 32'd42, 32'hFFFFFFFF, 1'b0, S + 1);
`endif

        // start held every cycle: second acceptance only when ready returns
        @(negedge clk);
        wait_ready();
        bus.a_in = 32'd100; bus.b_in = 32'd7; bus.start = 1'b1;
        push_exp(32'd2, 32'd14, 1'b0, S + 1);
        @(negedge clk);
        bus.a_in = 32'd9; bus.b_in = 32'd4;
        begin
            int k;
            k = 0;
            while (bus.ready !== 1'b1 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        push_exp(32'd1, 32'd2, 1'b0, S + 1);
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Clear during SETTLE discards the operation
        @(negedge clk);
        wait_ready();
        d0 = n_done;
        bus.a_in = 32'd1000; bus.b_in = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("clr_ready", {31'd0, bus.ready}, 32'd1);
        check("clr_hi", bus.hi_out, 32'd0);
        check("clr_lo", bus.lo_out, 32'd0);
        repeat (10) @(negedge clk);
        check("clr_no_done", n_done, d0);

        // Operation after clear still works
        do_op(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, S + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
